// File: rtl/l1d_evict_wr_adapter_pkg.sv
// Shared definitions for the L1D evict write adapter.
//   L1D_MSHR_ID_WIDTH : MSHR ID width carried with every evicted line
//   L1D_ADDR_WIDTH    : downstream line address width
//   DATA_RAM_WIDTH    : full cache line width as read from the data RAM
//   pack_evict_entry  : one FIFO entry {id, dat}
//   evict_wr_state_e  : write-issue FSM states
package l1d_evict_wr_adapter_pkg;

  localparam int L1D_MSHR_ID_WIDTH = 4;
  localparam int L1D_ADDR_WIDTH    = 32;
  localparam int DATA_RAM_WIDTH    = 256;

  typedef struct packed {
    logic [L1D_MSHR_ID_WIDTH-1:0] id;
    logic [DATA_RAM_WIDTH-1:0]    dat;
  } pack_evict_entry;

  localparam int EVICT_ENTRY_W = $bits(pack_evict_entry);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } evict_wr_state_e;

endpackage

// File: rtl/l1d_sync_fifo.sv
// Synchronous FIFO holding evicted lines.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   i_push     : write i_push_dat; accepted when not full or when popping
//   i_pop      : drop the head entry; ignored when empty
//   o_pop_dat  : current head entry (combinational read)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : number of valid entries, $clog2(DEPTH)+1 bits
module l1d_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_bad_depth
    $error("l1d_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];

  // A push at full is still taken when the head leaves on the same edge:
  // the freed slot is exactly the one wr_ptr points at.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/l1d_evict_wr_adapter.sv
// Evict write adapter: buffers full-line evictions from the data RAM pipe,
// issues each line downstream as BEATS beats, waits for the matching write
// ack and signals completion to the MSHR.
// Optional: define L1D_EVICT_ACK_TIMEOUT_EN to build the ack timeout
// counter driving evict_tmo_err (tied 0 otherwise).
//   clk, rst          : clock, synchronous active-high reset
//   evict_en/id/dat   : line push from data RAM pipe (no backpressure)
//   evict_afull       : at most one free entry left
//   mshr_lkp_id/addr  : head ID out, its line address back (combinational)
//   ds_wr_*           : downstream write beat channel, valid/ready
//   ds_wr_ack_vld/id  : downstream write completion
//   evict_done_en/id  : one-cycle completion pulse to MSHR
//   evict_ovf_err     : sticky, push dropped at full
//   evict_tmo_err     : sticky, ack timeout
module l1d_evict_wr_adapter
  import l1d_evict_wr_adapter_pkg::*;
#(
  parameter int EVICT_FIFO_DEPTH = 4,
  parameter int DS_DATA_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evict_en,
  input  logic [L1D_MSHR_ID_WIDTH-1:0] evict_id,
  input  logic [DATA_RAM_WIDTH-1:0]    evict_dat,
  output logic                         evict_afull,
  output logic [L1D_MSHR_ID_WIDTH-1:0] mshr_lkp_id,
  input  logic [L1D_ADDR_WIDTH-1:0]    mshr_lkp_addr,
  output logic                         ds_wr_vld,
  input  logic                         ds_wr_rdy,
  output logic [L1D_ADDR_WIDTH-1:0]    ds_wr_addr,
  output logic [L1D_MSHR_ID_WIDTH-1:0] ds_wr_id,
  output logic [DS_DATA_WIDTH-1:0]     ds_wr_dat,
  output logic                         ds_wr_last,
  input  logic                         ds_wr_ack_vld,
  input  logic [L1D_MSHR_ID_WIDTH-1:0] ds_wr_ack_id,
  output logic                         evict_done_en,
  output logic [L1D_MSHR_ID_WIDTH-1:0] evict_done_id,
  output logic                         evict_ovf_err,
  output logic                         evict_tmo_err
);

  localparam int BEATS  = DATA_RAM_WIDTH / DS_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(EVICT_FIFO_DEPTH) + 1;

  if ((BEATS < 1) || (BEATS * DS_DATA_WIDTH != DATA_RAM_WIDTH)) begin : g_bad_width
    $error("l1d_evict_wr_adapter: DATA_RAM_WIDTH must be a multiple of DS_DATA_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("l1d_evict_wr_adapter: TIMEOUT_CYCLES must be at least 1");
  end

  pack_evict_entry                         w_push_entry;
  pack_evict_entry                         w_head;
  logic [BEATS-1:0][DS_DATA_WIDTH-1:0]     w_head_beats;
  logic                                    w_fifo_full;
  logic                                    w_fifo_empty;
  logic [CNT_W-1:0]                        w_fifo_count;

  evict_wr_state_e                         r_state;
  evict_wr_state_e                         w_state_nxt;
  logic                                    w_load;
  logic                                    w_pop;
  logic                                    w_beat_hs;

  logic [BEAT_W-1:0]                       r_beat_cnt;
  logic [L1D_ADDR_WIDTH-1:0]               r_wr_addr;
  logic [L1D_MSHR_ID_WIDTH-1:0]            r_wr_id;
  logic                                    r_done_en;
  logic [L1D_MSHR_ID_WIDTH-1:0]            r_done_id;
  logic                                    r_ovf_err;

  assign w_push_entry.id  = evict_id;
  assign w_push_entry.dat = evict_dat;

  l1d_sync_fifo #(
    .WIDTH (EVICT_ENTRY_W),
    .DEPTH (EVICT_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (evict_en),
    .i_push_dat (w_push_entry),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  // Two free entries are needed at the arbiter: one for a read already in
  // the RAM pipe plus the one it would issue now.
  assign evict_afull = (CNT_W'(EVICT_FIFO_DEPTH) - w_fifo_count) <= CNT_W'(1);

  assign mshr_lkp_id  = w_head.id;
  assign w_head_beats = w_head.dat;

  // Beat data is read straight out of the head entry; the head cannot move
  // until the ack, so it stays stable under backpressure.
  assign ds_wr_dat  = w_head_beats[r_beat_cnt];
  assign ds_wr_addr = r_wr_addr;
  assign ds_wr_id   = r_wr_id;
  assign w_beat_hs  = ds_wr_vld && ds_wr_rdy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    ds_wr_vld   = 1'b0;
    ds_wr_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        ds_wr_vld  = 1'b1;
        ds_wr_last = (r_beat_cnt == BEAT_W'(BEATS - 1));
        if (ds_wr_rdy && ds_wr_last) w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ds_wr_ack_vld && (ds_wr_ack_id == r_wr_id)) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_wr_addr  <= '0;
      r_wr_id    <= '0;
      r_done_en  <= 1'b0;
      r_done_id  <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_wr_addr  <= mshr_lkp_addr;
        r_wr_id    <= w_head.id;
        r_beat_cnt <= '0;
      end else if (w_beat_hs) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
      r_done_en <= w_pop;
      if (w_pop) r_done_id <= r_wr_id;
      if (evict_en && w_fifo_full && !w_pop) r_ovf_err <= 1'b1;
    end
  end

  assign evict_done_en = r_done_en;
  assign evict_done_id = r_done_id;
  assign evict_ovf_err = r_ovf_err;

`ifdef L1D_EVICT_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // Counts WAIT_ACK cycles and saturates at TIMEOUT_CYCLES; the FSM keeps
  // waiting, the error only flags the stuck write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else if ((r_state == SEND) && (w_state_nxt == WAIT_ACK)) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == WAIT_ACK) && (r_tmo_cnt != TMO_W'(TIMEOUT_CYCLES))) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) r_tmo_err <= 1'b1;
    end
  end

  assign evict_tmo_err = r_tmo_err;
`else
  assign evict_tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_l1d_evict_wr_adapter.sv
module tb_l1d_evict_wr_adapter;
  import l1d_evict_wr_adapter_pkg::*;

  localparam int DEPTH = 4;
  localparam int DSW   = 64;
  localparam int BEATS = DATA_RAM_WIDTH / DSW;
  localparam int IDW   = L1D_MSHR_ID_WIDTH;
  localparam int AW    = L1D_ADDR_WIDTH;
`ifdef L1D_EVICT_ACK_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      evict_en;
  logic [IDW-1:0]            evict_id;
  logic [DATA_RAM_WIDTH-1:0] evict_dat;
  logic                      evict_afull;
  logic [IDW-1:0]            mshr_lkp_id;
  logic [AW-1:0]             mshr_lkp_addr;
  logic                      ds_wr_vld;
  logic                      ds_wr_rdy;
  logic [AW-1:0]             ds_wr_addr;
  logic [IDW-1:0]            ds_wr_id;
  logic [DSW-1:0]            ds_wr_dat;
  logic                      ds_wr_last;
  logic                      ds_wr_ack_vld;
  logic [IDW-1:0]            ds_wr_ack_id;
  logic                      evict_done_en;
  logic [IDW-1:0]            evict_done_id;
  logic                      evict_ovf_err;
  logic                      evict_tmo_err;

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] lkp_model(logic [IDW-1:0] id);
    return AW'(32'hA000_0000) | (AW'(id) << 6);
  endfunction

  assign mshr_lkp_addr = lkp_model(mshr_lkp_id);

  l1d_evict_wr_adapter #(
    .EVICT_FIFO_DEPTH (DEPTH),
    .DS_DATA_WIDTH    (DSW),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .evict_en      (evict_en),
    .evict_id      (evict_id),
    .evict_dat     (evict_dat),
    .evict_afull   (evict_afull),
    .mshr_lkp_id   (mshr_lkp_id),
    .mshr_lkp_addr (mshr_lkp_addr),
    .ds_wr_vld     (ds_wr_vld),
    .ds_wr_rdy     (ds_wr_rdy),
    .ds_wr_addr    (ds_wr_addr),
    .ds_wr_id      (ds_wr_id),
    .ds_wr_dat     (ds_wr_dat),
    .ds_wr_last    (ds_wr_last),
    .ds_wr_ack_vld (ds_wr_ack_vld),
    .ds_wr_ack_id  (ds_wr_ack_id),
    .evict_done_en (evict_done_en),
    .evict_done_id (evict_done_id),
    .evict_ovf_err (evict_ovf_err),
    .evict_tmo_err (evict_tmo_err)
  );

  typedef struct {
    logic [AW-1:0]  addr;
    logic [IDW-1:0] id;
    logic [DSW-1:0] dat;
    logic           last;
  } beat_t;

  beat_t          exp_q[$];
  logic [IDW-1:0] done_q[$];
  int             n_cmp = 0;
  int             n_mis = 0;
  int             hs_count = 0;
  int             last_count = 0;

  task automatic check(string name, logic [DATA_RAM_WIDTH-1:0] act, logic [DATA_RAM_WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: event not as required at %0t", name, $time);
  endtask

  // Word b = {seed, id, b, 16'h0123}; word 0 ends up in the LSBs.
  function automatic logic [DATA_RAM_WIDTH-1:0] make_dat(logic [IDW-1:0] id, logic [31:0] seed);
    logic [DATA_RAM_WIDTH-1:0] d = '0;
    for (int b = BEATS - 1; b >= 0; b--)
      d = (d << DSW) | DATA_RAM_WIDTH'({seed, 8'(id), 8'(b), 16'h0123});
    return d;
  endfunction

  function automatic logic [DSW-1:0] word_of(logic [DATA_RAM_WIDTH-1:0] d, int b);
    return DSW'(d >> (DSW * b));
  endfunction

  task automatic expect_line(logic [IDW-1:0] id, logic [DATA_RAM_WIDTH-1:0] dat);
    beat_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.addr = lkp_model(id);
      e.id   = id;
      e.dat  = word_of(dat, b);
      e.last = (b == BEATS - 1);
      exp_q.push_back(e);
    end
    done_q.push_back(id);
  endtask

  task automatic push(logic [IDW-1:0] id, logic [DATA_RAM_WIDTH-1:0] dat, bit accept);
    evict_en  = 1'b1;
    evict_id  = id;
    evict_dat = dat;
    if (accept) expect_line(id, dat);
    @(posedge clk); #1;
    evict_en = 1'b0;
  endtask

  task automatic ack(logic [IDW-1:0] id);
    @(posedge clk); #1;
    ds_wr_ack_vld = 1'b1;
    ds_wr_ack_id  = id;
    @(posedge clk); #1;
    ds_wr_ack_vld = 1'b0;
  endtask

  task automatic wait_last(int target);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (last_count >= target) return;
    end
    fail_now("wait_last_timeout");
  endtask

  task automatic wait_hs(int target);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (hs_count >= target) return;
    end
    fail_now("wait_hs_timeout");
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ds_wr_vld && ds_wr_rdy) begin
          hs_count++;
          if (ds_wr_last) last_count++;
          if (exp_q.size() == 0) begin
            fail_now("beat_unexpected");
          end else begin
            e = exp_q.pop_front();
            check("beat_dat", ds_wr_dat, e.dat);
            check("beat_addr", ds_wr_addr, e.addr);
            check("beat_id", ds_wr_id, e.id);
            check("beat_last", ds_wr_last, e.last);
          end
        end
        if (evict_done_en) begin
          if (done_q.size() == 0) fail_now("done_unexpected");
          else check("done_id", evict_done_id, done_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    logic [DATA_RAM_WIDTH-1:0] d;
    logic [IDW-1:0]            ids[5];
    int                        base;

    rst           = 1'b1;
    evict_en      = 1'b0;
    evict_id      = '0;
    evict_dat     = '0;
    ds_wr_rdy     = 1'b1;
    ds_wr_ack_vld = 1'b0;
    ds_wr_ack_id  = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", ds_wr_vld, 0);
    check("rst_last", ds_wr_last, 0);
    check("rst_done", evict_done_en, 0);
    check("rst_ovf", evict_ovf_err, 0);
    check("rst_tmo", evict_tmo_err, 0);
    check("rst_afull", evict_afull, 0);
    check("rst_addr", ds_wr_addr, 0);
    check("rst_id", ds_wr_id, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single eviction, no backpressure.
    base = last_count;
    push(4'd3, make_dat(4'd3, 32'h1111_0000), 1'b1);
    wait_last(base + 1);
    ack(4'd3);
    @(posedge clk); #1;
    check("t1_no_second_done", evict_done_en, 0);

    // Backpressure on beat 1.
    base = hs_count;
    d = make_dat(4'd4, 32'h2222_0000);
    push(4'd4, d, 1'b1);
    wait_hs(base + 1);
    ds_wr_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t2_hold_vld", ds_wr_vld, 1);
      check("t2_hold_dat", ds_wr_dat, word_of(d, 1));
      check("t2_hold_addr", ds_wr_addr, lkp_model(4'd4));
      check("t2_hold_id", ds_wr_id, 4'd4);
    end
    ds_wr_rdy = 1'b1;
    wait_last(last_count + 1);
    ack(4'd4);
    repeat (2) @(posedge clk);
    #1;
    check("t2_handshakes", hs_count - base, BEATS);

    // Mismatching ack ignored.
    base = last_count;
    push(4'd2, make_dat(4'd2, 32'h5555_0000), 1'b1);
    wait_last(base + 1);
    ack(4'd5);
    check("t5_bogus_ack_done", evict_done_en, 0);
    @(posedge clk); #1;
    check("t5_bogus_ack_done2", evict_done_en, 0);
    ack(4'd2);
    repeat (2) @(posedge clk);
    #1;

    // Fill to full with acks withheld, then overflow.
    ids[0] = 4'hA; ids[1] = 4'hB; ids[2] = 4'hC; ids[3] = 4'hD;
    base = last_count;
    for (int i = 0; i < 4; i++) begin
      push(ids[i], make_dat(ids[i], 32'h3333_0000 + i), 1'b1);
      check("t3_afull", evict_afull, (i + 1 >= 3) ? 1 : 0);
    end
    check("t3_ovf_before", evict_ovf_err, 0);
    push(4'hE, make_dat(4'hE, 32'hDEAD_0000), 1'b0);
    check("t3_ovf_set", evict_ovf_err, 1);
    check("t3_afull_full", evict_afull, 1);
    for (int k = 0; k < 4; k++) begin
      wait_last(base + k + 1);
      ack(ids[k]);
    end
    repeat (2) @(posedge clk);
    #1;
    check("t3_afull_drained", evict_afull, 0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ovf_cleared", evict_ovf_err, 0);

    // Push at full on the same edge as the ack pop.
    ids[0] = 4'h8; ids[1] = 4'h9; ids[2] = 4'hA; ids[3] = 4'hB; ids[4] = 4'hC;
    base = last_count;
    for (int i = 0; i < 4; i++) push(ids[i], make_dat(ids[i], 32'h4444_0000 + i), 1'b1);
    wait_last(base + 1);
    check("t4_full_before", evict_afull, 1);
    ds_wr_ack_vld = 1'b1;
    ds_wr_ack_id  = ids[0];
    evict_en      = 1'b1;
    evict_id      = ids[4];
    evict_dat     = make_dat(ids[4], 32'h4444_00FF);
    expect_line(ids[4], evict_dat);
    @(posedge clk); #1;
    ds_wr_ack_vld = 1'b0;
    evict_en      = 1'b0;
    check("t4_ovf_stays0", evict_ovf_err, 0);
    check("t4_still_full", evict_afull, 1);
    for (int k = 1; k < 5; k++) begin
      wait_last(base + k + 1);
      ack(ids[k]);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a burst.
    base = hs_count;
    push(4'd6, make_dat(4'd6, 32'h6666_0000), 1'b1);
    wait_hs(base + 2);
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_vld_after_rst", ds_wr_vld, 0);
    check("t6_done_after_rst", evict_done_en, 0);
    check("t6_afull_after_rst", evict_afull, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t6_idle_after_rst", ds_wr_vld, 0);
      check("t6_no_done", evict_done_en, 0);
    end
    base = last_count;
    push(4'd7, make_dat(4'd7, 32'h7777_0000), 1'b1);
    wait_last(base + 1);
    ack(4'd7);
    repeat (2) @(posedge clk);
    #1;

`ifdef L1D_EVICT_ACK_TIMEOUT_EN
    base = last_count;
    push(4'd1, make_dat(4'd1, 32'h8888_0000), 1'b1);
    wait_last(base + 1);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_not_yet", evict_tmo_err, 0);
    @(posedge clk); #1;
    check("tmo_set", evict_tmo_err, 1);
    ack(4'd1);
    repeat (2) @(posedge clk);
    #1;
    check("tmo_sticky", evict_tmo_err, 1);
`else
    check("tmo_tied_off", evict_tmo_err, 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("beats_outstanding", exp_q.size(), 0);
    check("dones_outstanding", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
